// File: rtl/uart_pkg.sv
// uart_pkg: parity modes and transmit FSM encoding
// shared by the UART transmitter files.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: single-clock transmit FIFO with
// occupancy count; head word is read combinationally.
module uart_tx_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [DW-1:0]            wdata_i,
  output logic [DW-1:0]            rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   lvl_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (lvl_q == (AW+1)'(DEPTH));
  assign empty_o = (lvl_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_q];
  assign level_o = lvl_q;

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

  // pointers wrap naturally: DEPTH is a power of two
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      unique case (1'b1)
        do_push && !do_pop: lvl_q <= lvl_q + 1'b1;
        do_pop && !do_push: lvl_q <= lvl_q - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_parity_fifo.sv
// uart_tx_parity_fifo: FIFO-buffered UART transmitter with
// optional parity, 1/2 stop bits and CTS_n flow control.
module uart_tx_parity_fifo
  import uart_pkg::*;
#(
  parameter int FREQ       = 50_000_000,
  parameter int BAUDRATE   = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          CLK,
  input  logic                          RESET_n,
  input  logic                          TX_REQ,
  input  logic [DATA_BITS-1:0]          DATA_IN,
  input  logic                          CTS_n,
  output logic                          TX,
  output logic                          IDLE,
  output logic                          FULL,
  output logic [$clog2(FIFO_DEPTH):0]   LEVEL,
  output logic                          OVERFLOW
);

  localparam int T  = FREQ / BAUDRATE;
  localparam int CW = (T > 1) ? $clog2(T) : 1;
  localparam logic [CW-1:0] T_LAST  = CW'(T - 1);
  localparam logic [2:0]    DB_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]    SB_LAST = 3'(STOP_BITS - 1);
  localparam logic          PAR_INV = (PARITY == PAR_ODD);
  localparam logic          HAS_PAR = (PARITY != PAR_NONE);

  state_e                 state_q;
  logic [CW-1:0]          cnt_q;
  logic [2:0]             bit_q;
  logic [DATA_BITS-1:0]   sh_q;
  logic                   par_q;
  logic                   tx_q;
  logic                   idle_q;
  logic                   ovf_q;

  logic                   f_empty;
  logic                   f_full;
  logic [DATA_BITS-1:0]   f_rdata;
  logic                   tick;
  logic                   can_go;
  logic                   pop;

  uart_tx_fifo #(
    .DW    (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_ni  (RESET_n),
    .push_i  (TX_REQ),
    .pop_i   (pop),
    .wdata_i (DATA_IN),
    .rdata_o (f_rdata),
    .full_o  (f_full),
    .empty_o (f_empty),
    .level_o (LEVEL)
  );

  assign tick   = (cnt_q == T_LAST);
  assign can_go = !f_empty && !CTS_n;
  // a new frame may follow the last stop bit with no gap
  assign pop    = can_go &&
                  ((state_q == S_IDLE) ||
                   (state_q == S_STOP && tick && bit_q == SB_LAST));

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      idle_q  <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      ovf_q  <= TX_REQ && f_full;
      idle_q <= f_empty && (state_q == S_IDLE);
      unique case (state_q)
        S_START:  tx_q <= 1'b0;
        S_DATA:   tx_q <= sh_q[0];
        S_PARITY: tx_q <= par_q;
        default:  tx_q <= 1'b1;
      endcase
      if (state_q == S_IDLE || tick) cnt_q <= '0;
      else                           cnt_q <= cnt_q + 1'b1;
      if (pop) begin
        state_q <= S_START;
        sh_q    <= f_rdata;
        par_q   <= (^f_rdata) ^ PAR_INV;
        bit_q   <= '0;
      end else if (tick) begin
        unique case (state_q)
          S_START: state_q <= S_DATA;
          S_DATA: begin
            sh_q <= sh_q >> 1;
            if (bit_q == DB_LAST) begin
              bit_q   <= '0;
              state_q <= HAS_PAR ? S_PARITY : S_STOP;
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end
          S_PARITY: state_q <= S_STOP;
          S_STOP: begin
            if (bit_q == SB_LAST) begin
              bit_q   <= '0;
              state_q <= S_IDLE;
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign TX       = tx_q;
  assign IDLE     = idle_q;
  assign OVERFLOW = ovf_q;
  assign FULL     = f_full;

endmodule

// File: doc/uart_tx_parity_fifo.md
UART_TX_PARITY_FIFO -- requirements
Module: uart_tx_parity_fifo

Interface
REQ-001 SHALL have parameter FREQ, default 50_000_000: system clock frequency in Hz.
REQ-002 SHALL have parameter BAUDRATE, default 115200: line rate; bit period T = FREQ/BAUDRATE clocks (integer division).
REQ-003 SHALL have parameter DATA_BITS, default 8: data bits per frame, legal 5..8.
REQ-004 SHALL have parameter PARITY, default 0: 0 = none, 1 = odd, 2 = even.
REQ-005 SHALL have parameter STOP_BITS, default 1: legal 1 or 2.
REQ-006 SHALL have parameter FIFO_DEPTH, default 16: transmit FIFO entries, a power of 2 and at least 2.
REQ-007 SHALL have port CLK, input, 1: the single clock, rising edge.
REQ-008 SHALL have port RESET_n, input, 1: asynchronous, active-low reset.
REQ-009 SHALL have port TX_REQ, input, 1: write strobe; one byte per high cycle.
REQ-010 SHALL have port DATA_IN, input, DATA_BITS: byte written on TX_REQ.
REQ-011 SHALL have port CTS_n, input, 1: clear-to-send, active low; gates frame starts only.
REQ-012 SHALL have port TX, output, 1: serial line, idle high.
REQ-013 SHALL have port IDLE, output, 1: high when the FIFO is empty and no frame is in progress.
REQ-014 SHALL have port FULL, output, 1: FIFO holds FIFO_DEPTH entries.
REQ-015 SHALL have port LEVEL, output, $clog2(FIFO_DEPTH)+1: current FIFO occupancy.
REQ-016 SHALL have port OVERFLOW, output, 1: one-cycle pulse when a write is dropped.

Function
REQ-017 SHALL push DATA_IN on any edge where TX_REQ=1 and FULL=0 (pre-edge value). A simultaneous pop does not make a full FIFO writable.
REQ-018 SHALL drop a write with TX_REQ=1 and FULL=1 and pulse OVERFLOW high for exactly the next cycle.
REQ-019 SHALL use FSM states S_IDLE, S_START, S_DATA, S_PARITY, S_STOP.
REQ-020 SHALL leave S_IDLE, pop the FIFO head into the shift register, and enter S_START on the edge where FIFO non-empty and CTS_n=0.
REQ-021 SHALL hold each bit on TX for exactly T clocks: start = 0, data LSB first, parity, then STOP_BITS ones.
REQ-022 SHALL skip S_PARITY when PARITY=0; parity bit = XOR of data bits for even, its inverse for odd.
REQ-023 SHALL, at the end of the last stop bit, enter S_START directly (zero gap) if the FIFO is non-empty and CTS_n=0; otherwise enter S_IDLE.
REQ-024 SHALL complete a frame already in progress when CTS_n rises; no new start while CTS_n=1.
REQ-025 SHALL, from write to an empty FIFO with FSM idle and CTS_n=0, pop on the next edge and drive TX low on the edge after (two-cycle latency).
REQ-026 SHALL register TX; no combinational path from any input to TX.
REQ-027 SHALL wrap the baud counter to 0 at T-1; counter width is $clog2(T).
REQ-028 SHALL update LEVEL as +1 push, -1 pop, unchanged for both or neither; FULL = (LEVEL == FIFO_DEPTH).

Reset
REQ-029 SHALL, with RESET_n low, immediately force TX=1, IDLE=1, FULL=0, LEVEL=0, OVERFLOW=0, FSM=S_IDLE, pointers and counters 0.
REQ-030 SHALL abort any frame and discard FIFO contents on reset mid-frame; no partial frame resumes.

Structure
REQ-031 SHALL take parity-mode constants and the FSM state encoding from shared package uart_pkg.
REQ-032 SHALL implement the FIFO as sub-module uart_tx_fifo (synchronous, single clock, push/pop/full/empty/level).

Verification (FREQ=50e6, BAUDRATE=115200, T=434)
REQ-033 SHALL check 8N1, write 0x41 -> TX = 0,1,0,0,0,0,0,1,0,1, each 434 clocks; IDLE low from the edge after the write to the end of the stop bit.
REQ-034 SHALL check DATA_BITS=7, even parity, 2 stop, write 0x35 -> TX = 0,1,0,1,0,1,1,0, parity 0, then 1,1; 11 bits in total.
REQ-035 SHALL check 8O1, write 0xFF -> parity bit 1; frame 0, eight 1s, 1, 1.
REQ-036 SHALL check FIFO_DEPTH=4 with 6 consecutive writes from idle -> writes 1-5 accepted, FULL after the 5th, OVERFLOW pulse on the 6th, five frames with no idle gap.
REQ-037 SHALL check CTS_n raised during data bit 3 of frame 1 with 2 queued -> frame 1 completes, TX stays high, frame 2 starts 2 cycles after CTS_n falls.
REQ-038 SHALL check RESET_n pulsed low mid data bit with LEVEL=3 -> TX=1 asynchronously, LEVEL=0, IDLE=1, no further frames.
